id_decode_pipe: RTL and testbench
=================================

ID_DECODE_PIPE -- requirements
Module: id_decode_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register/operand data width (16..64).
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, 2..32); RA_W = log2(NREG), and register addresses use instn fields truncated to RA_W bits.
REQ-003 SHALL have parameter PERI_BASE, default 256, lowest store address routed to the peripheral port.
REQ-004 SHALL have ports: clk in 1 rising-edge clock; rst in 1 asynchronous active-high reset.
REQ-005 SHALL have ports: in_valid in 1; in_ready out 1; instn in 32 instruction word.
REQ-006 SHALL have ports: wb_we in 1; wb_addr in 5; wb_data in DATA_W write-back port.
REQ-007 SHALL have ports: ex_memread in 1 and ex_rt in 5 (load in EX); br_resolve in 1 and br_taken in 1 (branch outcome from EX).
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; out_rs_data, out_rt_data out DATA_W; out_opcode out 6; out_rs, out_rt, out_rd, out_shamt out 5; out_funct out 6; out_immd out DATA_W sign-extended.
REQ-009 SHALL have ports: out_reg_dst, out_alu_src, out_branch, out_mem_write, out_reg_write, out_mem_to_reg out 1 each; out_alu_op out 2.
REQ-010 SHALL have ports: peri_we out 1 active-high; peri_addr out 16; peri_wdata out 16.

Function
REQ-011 Register file: NREG x DATA_W, written at clk edge when wb_we and wb_addr!=0; register 0 reads 0 always.
REQ-012 Same-cycle write-through: read address equal to a nonzero wb_addr with wb_we returns wb_data.
REQ-013 Decode (opcode=instn[31:26]): 0x00 R-type reg_dst=1,reg_write=1,alu_op=10; 0x23 lw alu_src=1,mem_to_reg=1,reg_write=1,alu_op=00; 0x2B sw alu_src=1,mem_write=1; 0x04 beq branch=1,alu_op=01; 0x08 addi alu_src=1,reg_write=1; any other opcode all controls 0.
REQ-014 Output register: all out_* load on accept (in_valid&&in_ready); out_valid set on accept, cleared when out_ready&&!accept; outputs hold while out_valid&&!out_ready.
REQ-015 in_ready = (!out_valid||out_ready) && !hazard && fsm!=BR_WAIT.
REQ-016 Load-use hazard: ex_memread && ex_rt!=0 && (ex_rt==rs || (ex_rt==rt && opcode in {0x00,0x2B,0x04})); while hazard and out_ready, out_valid drops to 0 (bubble).
REQ-017 FSM states IDLE, BR_WAIT, FLUSH; IDLE->BR_WAIT on accepting beq; BR_WAIT->FLUSH on br_resolve&&br_taken; BR_WAIT->IDLE on br_resolve&&!br_taken; FLUSH->IDLE after one cycle.
REQ-018 In FLUSH in_ready=1 and any presented instruction is consumed and discarded (out_valid not set, no peri write).
REQ-019 br_resolve outside BR_WAIT is ignored.
REQ-020 Peripheral store: accepted sw with zero-extended instn[15:0] >= PERI_BASE pulses peri_we for exactly one cycle after accept with peri_addr=instn[15:0], peri_wdata=rt data[15:0]; that instruction's out_mem_write=0.
REQ-021 peri_addr and peri_wdata SHALL be 0 whenever peri_we=0.

Reset
REQ-022 rst asserted: all registers 0, FSM IDLE, all outputs 0 including out_valid and peri_we, asynchronously; in_ready=1 after release.
REQ-023 rst mid-operation discards any in-flight instruction and pending branch wait.

Verification
REQ-024 Write r5=0x1234 and read rs=5 same cycle -> out_rs_data=0x1234 one cycle later; write r0=0xFFFF -> reads 0.
REQ-025 ex_memread=1, ex_rt=3, instn add rs=3 -> in_ready=0, out_valid=0 next cycle; drop ex_memread -> accepted, out_valid=1.
REQ-026 Accept beq, pulse br_resolve with br_taken=1 -> in_ready=0 until resolve, next instruction discarded, following one decoded normally.
REQ-027 sw rt=r2 (0xABCD1234), imm=0x0100 -> peri_we=1 one cycle, peri_addr=0x0100, peri_wdata=0x1234, out_mem_write=0; imm=0x00FF -> peri_we=0, out_mem_write=1.
REQ-028 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; rst pulse in BR_WAIT -> out_valid=0, FSM IDLE, in_ready=1.

Source files
------------

// File: rtl/id_decode_pipe.sv
// id_decode_pipe: instruction decode stage with register file, load-use stall,
// branch wait/flush sequencing and a memory-mapped peripheral store port.
module id_decode_pipe #(
    parameter int          DATA_W    = 32,
    parameter int          NREG      = 32,
    parameter int unsigned PERI_BASE = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instn,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_memread,
    input  logic [4:0]        ex_rt,
    input  logic              br_resolve,
    input  logic              br_taken,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_funct,
    output logic [DATA_W-1:0] out_immd,
    output logic              out_reg_dst,
    output logic              out_alu_src,
    output logic              out_branch,
    output logic              out_mem_write,
    output logic              out_reg_write,
    output logic              out_mem_to_reg,
    output logic [1:0]        out_alu_op,
    output logic              peri_we,
    output logic [15:0]       peri_addr,
    output logic [15:0]       peri_wdata
);
    localparam int RA_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [1:0] IDLE = 2'd0, BR_WAIT = 2'd1, FLUSH = 2'd2;
    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_ADDI = 6'h08;

    logic [DATA_W-1:0] regs [NREG];
    logic [1:0]        state;
    logic [5:0]        opcode;
    logic [RA_W-1:0]   rs_idx, rt_idx, wa;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic is_r, is_lw, is_sw, is_beq, is_addi, hazard, flush, accept, take, peri_hit;

    assign opcode  = instn[31:26];
    assign rs_idx  = instn[RA_W+20:21];
    assign rt_idx  = instn[RA_W+15:16];
    assign wa      = wb_addr[RA_W-1:0];
    assign is_r    = opcode == OP_R;
    assign is_lw   = opcode == OP_LW;
    assign is_sw   = opcode == OP_SW;
    assign is_beq  = opcode == OP_BEQ;
    assign is_addi = opcode == OP_ADDI;

    // write-back in the same cycle is forwarded so decode never reads a stale value
    assign rs_data = (rs_idx == '0) ? '0 : (wb_we && wa == rs_idx) ? wb_data : regs[rs_idx];
    assign rt_data = (rt_idx == '0) ? '0 : (wb_we && wa == rt_idx) ? wb_data : regs[rt_idx];

    assign hazard   = ex_memread && ex_rt != 5'd0 &&
                      (ex_rt == instn[25:21] || (ex_rt == instn[20:16] && (is_r || is_sw || is_beq)));
    assign flush    = state == FLUSH;
    assign in_ready = flush || ((!out_valid || out_ready) && !hazard && state != BR_WAIT);
    assign accept   = in_valid && in_ready;
    assign take     = accept && !flush;
    assign peri_hit = is_sw && ({16'd0, instn[15:0]} >= PERI_BASE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        else if (wb_we && wa != '0)
            regs[wa] <= wb_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= flush ? IDLE :
                     (state == BR_WAIT) ? (br_resolve ? (br_taken ? FLUSH : IDLE) : BR_WAIT) :
                     (take && is_beq) ? BR_WAIT : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_rs_data    <= '0;
            out_rt_data    <= '0;
            out_opcode     <= '0;
            out_rs         <= '0;
            out_rt         <= '0;
            out_rd         <= '0;
            out_shamt      <= '0;
            out_funct      <= '0;
            out_immd       <= '0;
            out_reg_dst    <= 1'b0;
            out_alu_src    <= 1'b0;
            out_branch     <= 1'b0;
            out_mem_write  <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_alu_op     <= '0;
        end else if (take) begin
            out_valid      <= 1'b1;
            out_rs_data    <= rs_data;
            out_rt_data    <= rt_data;
            out_opcode     <= opcode;
            out_rs         <= instn[25:21];
            out_rt         <= instn[20:16];
            out_rd         <= instn[15:11];
            out_shamt      <= instn[10:6];
            out_funct      <= instn[5:0];
            out_immd       <= DATA_W'($signed(instn[15:0]));
            out_reg_dst    <= is_r;
            out_alu_src    <= is_lw || is_sw || is_addi;
            out_branch     <= is_beq;
            out_mem_write  <= is_sw && !peri_hit;
            out_reg_write  <= is_r || is_lw || is_addi;
            out_mem_to_reg <= is_lw;
            out_alu_op     <= is_r ? 2'b10 : is_beq ? 2'b01 : 2'b00;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peri_we    <= 1'b0;
            peri_addr  <= '0;
            peri_wdata <= '0;
        end else begin
            peri_we    <= take && peri_hit;
            peri_addr  <= (take && peri_hit) ? instn[15:0] : 16'd0;
            peri_wdata <= (take && peri_hit) ? rt_data[15:0] : 16'd0;
        end
    end
endmodule

// File: tb/tb_id_decode_pipe.sv
// tb_id_decode_pipe: directed-vector bench for id_decode_pipe with hand-computed expectations.
module tb_id_decode_pipe;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready;
    logic [31:0] instn = 0;
    logic        wb_we = 0;
    logic [4:0]  wb_addr = 0;
    logic [31:0] wb_data = 0;
    logic        ex_memread = 0;
    logic [4:0]  ex_rt = 0;
    logic        br_resolve = 0, br_taken = 0;
    logic        out_valid, out_ready = 1;
    logic [31:0] out_rs_data, out_rt_data, out_immd;
    logic [5:0]  out_opcode, out_funct;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic        out_reg_dst, out_alu_src, out_branch, out_mem_write, out_reg_write, out_mem_to_reg;
    logic [1:0]  out_alu_op;
    logic        peri_we;
    logic [15:0] peri_addr, peri_wdata;
    int checks = 0, failures = 0;

    id_decode_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instn(instn),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .br_resolve(br_resolve), .br_taken(br_taken),
        .out_valid(out_valid), .out_ready(out_ready), .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
        .out_funct(out_funct), .out_immd(out_immd), .out_reg_dst(out_reg_dst), .out_alu_src(out_alu_src),
        .out_branch(out_branch), .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
        .out_mem_to_reg(out_mem_to_reg), .out_alu_op(out_alu_op),
        .peri_we(peri_we), .peri_addr(peri_addr), .peri_wdata(peri_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_peri_we", peri_we, 0);
        check("rst_rs_data", out_rs_data, 0);
        step();
        rst = 0;
        #1;
        check("rel_in_ready", in_ready, 1);
        // same-cycle write-through
        wb_we = 1; wb_addr = 5; wb_data = 32'h1234;
        in_valid = 1; instn = r_ins(5, 0, 7);
        step();
        check("wt_valid", out_valid, 1);
        check("wt_rs_data", out_rs_data, 32'h1234);
        check("r_reg_dst", out_reg_dst, 1);
        check("r_reg_write", out_reg_write, 1);
        check("r_alu_op", out_alu_op, 2'b10);
        check("r_rd", out_rd, 7);
        check("r_funct", out_funct, 6'h20);
        wb_addr = 0; wb_data = 32'hFFFF; instn = r_ins(0, 5, 1);
        step();
        check("r0_reads0", out_rs_data, 0);
        check("r5_stored", out_rt_data, 32'h1234);
        in_valid = 0; wb_addr = 2; wb_data = 32'hABCD1234;
        step();
        wb_addr = 3; wb_data = 32'h55;
        step();
        wb_we = 0;
        check("idle_valid0", out_valid, 0);
        // load-use hazard
        ex_memread = 1; ex_rt = 3; in_valid = 1; instn = r_ins(3, 2, 4);
        #1;
        check("haz_in_ready", in_ready, 0);
        step();
        check("haz_bubble", out_valid, 0);
        ex_memread = 0;
        #1;
        check("haz_clear_ready", in_ready, 1);
        step();
        check("haz_accept", out_valid, 1);
        check("haz_rs_data", out_rs_data, 32'h55);
        check("haz_rt_data", out_rt_data, 32'hABCD1234);
        // lw: rt match is not a hazard
        ex_memread = 1; ex_rt = 3; instn = i_ins(6'h23, 0, 3, 16'hFFF0);
        #1;
        check("lw_no_haz", in_ready, 1);
        step();
        ex_memread = 0;
        check("lw_immd", out_immd, 32'hFFFFFFF0);
        check("lw_alu_src", out_alu_src, 1);
        check("lw_mem_to_reg", out_mem_to_reg, 1);
        check("lw_reg_write", out_reg_write, 1);
        check("lw_alu_op", out_alu_op, 0);
        // peripheral store boundary
        instn = i_ins(6'h2B, 0, 2, 16'h0100);
        step();
        check("sw_peri_we", peri_we, 1);
        check("sw_peri_addr", peri_addr, 16'h0100);
        check("sw_peri_wdata", peri_wdata, 16'h1234);
        check("sw_peri_memw", out_mem_write, 0);
        instn = i_ins(6'h2B, 0, 2, 16'h00FF);
        step();
        check("sw_mem_peri_we", peri_we, 0);
        check("sw_mem_peri_addr", peri_addr, 0);
        check("sw_mem_peri_wdata", peri_wdata, 0);
        check("sw_mem_memw", out_mem_write, 1);
        // backpressure
        instn = i_ins(6'h08, 2, 6, 16'd5);
        step();
        check("addi_alu_src", out_alu_src, 1);
        check("addi_reg_write", out_reg_write, 1);
        check("addi_reg_dst", out_reg_dst, 0);
        out_ready = 0; instn = r_ins(1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid", out_valid, 1);
            check("bp_opcode", out_opcode, 6'h08);
            check("bp_immd", out_immd, 5);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1; in_valid = 0;
        step();
        check("bp_drain", out_valid, 0);
        // unknown opcode
        in_valid = 1; instn = i_ins(6'h3F, 1, 1, 16'h1);
        step();
        check("unk_valid", out_valid, 1);
        check("unk_reg_write", out_reg_write, 0);
        check("unk_alu_src", out_alu_src, 0);
        check("unk_mem_write", out_mem_write, 0);
        in_valid = 0;
        // resolve outside BR_WAIT ignored
        br_resolve = 1; br_taken = 1;
        step();
        br_resolve = 0;
        step();
        check("stray_resolve", in_ready, 1);
        // beq rt hazard
        ex_memread = 1; ex_rt = 3; in_valid = 1; instn = i_ins(6'h04, 2, 3, 16'd4);
        #1;
        check("beq_rt_haz", in_ready, 0);
        ex_memread = 0;
        // taken branch
        step();
        check("beq_valid", out_valid, 1);
        check("beq_branch", out_branch, 1);
        check("beq_alu_op", out_alu_op, 2'b01);
        check("brw_in_ready", in_ready, 0);
        instn = i_ins(6'h08, 0, 6, 16'd7);
        step();
        check("brw_stall_ready", in_ready, 0);
        check("brw_valid0", out_valid, 0);
        br_resolve = 1; br_taken = 1;
        step();
        br_resolve = 0;
        check("flush_in_ready", in_ready, 1);
        step();
        check("flush_discard", out_valid, 0);
        check("flush_no_peri", peri_we, 0);
        instn = i_ins(6'h08, 0, 6, 16'd9);
        step();
        check("post_flush_valid", out_valid, 1);
        check("post_flush_immd", out_immd, 9);
        // not-taken branch
        instn = i_ins(6'h04, 2, 3, 16'd4);
        step();
        instn = i_ins(6'h08, 0, 6, 16'd11);
        br_resolve = 1; br_taken = 0;
        step();
        br_resolve = 0;
        check("nt_in_ready", in_ready, 1);
        step();
        check("nt_valid", out_valid, 1);
        check("nt_immd", out_immd, 11);
        // reset in BR_WAIT
        instn = i_ins(6'h04, 2, 3, 16'd4);
        step();
        in_valid = 0;
        check("rbw_in_ready", in_ready, 0);
        rst = 1;
        #1;
        check("rbw_valid", out_valid, 0);
        check("rbw_branch", out_branch, 0);
        rst = 0;
        step();
        check("rbw_ready", in_ready, 1);
        in_valid = 1; instn = r_ins(2, 3, 1);
        step();
        check("rbw_regs_cleared", out_rs_data, 0);
        check("rbw_accept", out_valid, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
